// File: rtl/twiddle_cmult_pipe_pkg.sv
// rtl/twiddle_cmult_pipe_pkg.sv - shared constants for the twiddle complex multiplier
package twiddle_cmult_pipe_pkg;

  localparam int DEF_DATA_W   = 22;
  localparam int DEF_TW_W     = 16;
  localparam int DEF_TAG_W    = 10;
  localparam int PIPE_LATENCY = 4;

  // Twiddles are Q1.(TW_W-1), so products carry TW_W-1 fraction bits.
  function automatic int frac_shift(input int tw_w);
    return tw_w - 1;
  endfunction

  function automatic int prod_w(input int data_w, input int tw_w);
    return data_w + tw_w + 2;
  endfunction

endpackage

// File: rtl/twiddle_cmult_pipe_if.sv
// rtl/twiddle_cmult_pipe_if.sv - sample/twiddle input and product output handshake bundle
interface twiddle_cmult_pipe_if
  import twiddle_cmult_pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int TW_W   = DEF_TW_W,
  parameter int TAG_W  = DEF_TAG_W
);

  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_re;
  logic signed [DATA_W-1:0] in_im;
  logic signed [TW_W-1:0]   tw_re;
  logic signed [TW_W-1:0]   tw_im;
  logic                     in_conj;
  logic                     in_round;
  logic [TAG_W-1:0]         in_tag;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_re;
  logic signed [DATA_W-1:0] out_im;
  logic [TAG_W-1:0]         out_tag;
  logic                     ovf;
  logic                     ovf_clr;

  modport master (
    output in_valid, in_re, in_im, tw_re, tw_im, in_conj, in_round, in_tag,
    output out_ready, ovf_clr,
    input  in_ready, out_valid, out_re, out_im, out_tag, ovf
  );

  modport slave (
    input  in_valid, in_re, in_im, tw_re, tw_im, in_conj, in_round, in_tag,
    input  out_ready, ovf_clr,
    output in_ready, out_valid, out_re, out_im, out_tag, ovf
  );

endinterface

// File: rtl/cmult_round_sat.sv
// rtl/cmult_round_sat.sv - optional round-half-up, arithmetic shift and saturation with clip flag
module cmult_round_sat #(
  parameter int IN_W  = 41,
  parameter int OUT_W = 22,
  parameter int SHIFT = 15
) (
  input  logic signed [IN_W-1:0]  x,
  input  logic                    rnd,
  output logic signed [OUT_W-1:0] y,
  output logic                    clip
);

  localparam logic signed [IN_W:0] ROUND_K = (IN_W+1)'(1) << (SHIFT-1);
  localparam logic signed [IN_W:0] MAX_V   = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] MIN_V   = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [IN_W:0] biased;
  logic signed [IN_W:0] shifted;

  always_comb begin
    biased = (IN_W+1)'(x);
    if (rnd) begin
      biased = biased + ROUND_K;
    end
    shifted = biased >>> SHIFT;
    clip    = 1'b1;
    if (shifted > MAX_V) begin
      y = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (shifted < MIN_V) begin
      y = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      y    = shifted[OUT_W-1:0];
      clip = 1'b0;
    end
  end

endmodule

// File: rtl/twiddle_cmult_pipe.sv
// rtl/twiddle_cmult_pipe.sv - 4-stage flow-controlled three-multiplier complex twiddle product
module twiddle_cmult_pipe
  import twiddle_cmult_pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int TW_W   = DEF_TW_W,
  parameter int TAG_W  = DEF_TAG_W
) (
  input logic                 clk,
  input logic                 rst_n,
  twiddle_cmult_pipe_if.slave bus
);

  localparam int PW = prod_w(DATA_W, TW_W);
  localparam int SW = PW + 1;

  logic                     en;
  logic                     v1, v2, v3, out_valid_q;
  logic signed [DATA_W-1:0] a1, b1;
  logic signed [TW_W-1:0]   c1;
  logic signed [TW_W:0]     d1, d_in;
  logic                     r1, r2, r3;
  logic [TAG_W-1:0]         t1, t2, t3, out_tag_q;
  logic signed [DATA_W:0]   pre1;
  logic signed [TW_W+1:0]   tsum1, tdiff1;
  logic signed [PW-1:0]     m0, m1, m2;
  logic signed [SW-1:0]     re3, im3;
  logic signed [DATA_W-1:0] y_re, y_im, out_re_q, out_im_q;
  logic                     clip_re, clip_im, ovf_q;

  // Whole pipeline advances together; a held output freezes every stage.
  assign en           = !out_valid_q || bus.out_ready;
  assign bus.in_ready = en;

  assign d_in   = bus.in_conj ? -(TW_W+1)'(bus.tw_im) : (TW_W+1)'(bus.tw_im);
  assign pre1   = (DATA_W+1)'(a1) + (DATA_W+1)'(b1);
  assign tsum1  = (TW_W+2)'(c1) + (TW_W+2)'(d1);
  assign tdiff1 = (TW_W+2)'(d1) - (TW_W+2)'(c1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0; out_valid_q <= 1'b0;
      a1 <= '0; b1 <= '0; c1 <= '0; d1 <= '0;
      m0 <= '0; m1 <= '0; m2 <= '0;
      re3 <= '0; im3 <= '0;
      r1 <= 1'b0; r2 <= 1'b0; r3 <= 1'b0;
      t1 <= '0; t2 <= '0; t3 <= '0;
      out_re_q <= '0; out_im_q <= '0; out_tag_q <= '0;
    end else if (en) begin
      v1 <= bus.in_valid;
      a1 <= bus.in_re;
      b1 <= bus.in_im;
      c1 <= bus.tw_re;
      d1 <= d_in;
      r1 <= bus.in_round;
      t1 <= bus.in_tag;

      v2 <= v1;
      m0 <= PW'(c1) * PW'(pre1);
      m1 <= PW'(a1) * PW'(tdiff1);
      m2 <= PW'(b1) * PW'(tsum1);
      r2 <= r1;
      t2 <= t1;

      v3  <= v2;
      re3 <= SW'(m0) - SW'(m2);
      im3 <= SW'(m0) + SW'(m1);
      r3  <= r2;
      t3  <= t2;

      out_valid_q <= v3;
      out_re_q    <= y_re;
      out_im_q    <= y_im;
      out_tag_q   <= t3;
    end
  end

  // A set on the same edge as a clear wins, so an overflow is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (en && v3 && (clip_re || clip_im)) begin
      ovf_q <= 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  cmult_round_sat #(.IN_W(SW), .OUT_W(DATA_W), .SHIFT(frac_shift(TW_W))) u_sat_re (
    .x    (re3),
    .rnd  (r3),
    .y    (y_re),
    .clip (clip_re)
  );

  cmult_round_sat #(.IN_W(SW), .OUT_W(DATA_W), .SHIFT(frac_shift(TW_W))) u_sat_im (
    .x    (im3),
    .rnd  (r3),
    .y    (y_im),
    .clip (clip_im)
  );

  assign bus.out_valid = out_valid_q;
  assign bus.out_re    = out_re_q;
  assign bus.out_im    = out_im_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_twiddle_cmult_pipe.sv
// tb/tb_twiddle_cmult_pipe.sv - scoreboard bench for the twiddle complex multiplier
module tb_twiddle_cmult_pipe;
  import twiddle_cmult_pipe_pkg::*;

  localparam int DW  = DEF_DATA_W;
  localparam int TWW = DEF_TW_W;
  localparam int TGW = DEF_TAG_W;

  typedef struct {
    longint re;
    longint im;
    int     tag;
    int     cyc;
    bit     lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  twiddle_cmult_pipe_if bus ();

  twiddle_cmult_pipe dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t   exp_q[$];
  exp_t   mon_e;
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     k = 0;
  bit     have_sample = 0;
  longint cur_re, cur_im;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint sat(input longint v);
    longint mx, mn;
    mx = (64'sd1 <<< (DW-1)) - 1;
    mn = -(64'sd1 <<< (DW-1));
    if (v > mx) return mx;
    if (v < mn) return mn;
    return v;
  endfunction

  // Reference uses the direct four-multiplier product.
  task automatic model(input longint a, input longint b, input longint c, input longint d,
                       input bit conj, input bit rnd, output longint re, output longint im);
    longint dd, pr, pi;
    dd = conj ? -d : d;
    pr = a * c - b * dd;
    pi = a * dd + b * c;
    if (rnd) begin
      pr = pr + (64'sd1 <<< (TWW-2));
      pi = pi + (64'sd1 <<< (TWW-2));
    end
    re = sat(pr >>> (TWW-1));
    im = sat(pi >>> (TWW-1));
  endtask

  task automatic drive(input longint a, input longint b, input longint c, input longint d,
                       input bit conj, input bit rnd, input int tag);
    bus.in_re    = DW'(a);
    bus.in_im    = DW'(b);
    bus.tw_re    = TWW'(c);
    bus.tw_im    = TWW'(d);
    bus.in_conj  = conj;
    bus.in_round = rnd;
    bus.in_tag   = TGW'(tag);
  endtask

  task automatic push(input longint re, input longint im, input int tag, input bit lat);
    exp_t e;
    e.re = re; e.im = im; e.tag = tag; e.cyc = cyc; e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic send(input longint a, input longint b, input longint c, input longint d,
                      input bit conj, input bit rnd, input int tag,
                      input longint ere, input longint eim, input bit lat);
    drive(a, b, c, d, conj, rnd, tag);
    bus.in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        push(ere, eim, tag, lat);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    checks++; errors++;
    $display("FAIL send_timeout: got no in_ready, expected accept of tag %0d", tag);
    bus.in_valid = 1'b0;
  endtask

  task automatic gen_sample();
    logic signed [DW-1:0]  ta, tb_v;
    logic signed [TWW-1:0] tc, td;
    bit conj, rnd;
    ta   = DW'($urandom);
    tb_v = DW'($urandom);
    tc   = TWW'($urandom);
    td   = TWW'($urandom);
    if (k % 10 == 9) begin
      ta   = {1'b1, {(DW-1){1'b0}}};
      tb_v = {1'b1, {(DW-1){1'b0}}};
      tc   = {1'b1, {(TWW-1){1'b0}}};
      td   = {1'b1, {(TWW-1){1'b0}}};
    end
    conj = 1'($urandom);
    rnd  = 1'($urandom);
    drive(ta, tb_v, tc, td, conj, rnd, k);
    model(ta, tb_v, tc, td, conj, rnd, cur_re, cur_im);
  endtask

  task automatic stream(input int target, input int max_cyc, input bit rnd_rdy);
    for (int t = 0; t < max_cyc && k < target; t++) begin
      if (!have_sample) begin
        gen_sample();
        have_sample = 1'b1;
      end
      bus.in_valid = 1'b1;
      @(negedge clk);
      if (bus.in_ready) begin
        push(cur_re, cur_im, k % (1 << TGW), 1'b0);
        k++;
        have_sample = 1'b0;
      end
      @(posedge clk); #1;
      if (rnd_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    if (k >= target) bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 400; t++) begin
      if (exp_q.size() == 0) begin
        @(posedge clk); #1;
        return;
      end
      @(negedge clk);
    end
    checks++; errors++;
    $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output: got tag %0d, expected no output", bus.out_tag);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_re", bus.out_re, mon_e.re);
        check("out_im", bus.out_im, mon_e.im);
        check("out_tag", bus.out_tag, mon_e.tag);
        if (mon_e.lat) check("latency", cyc - mon_e.cyc, PIPE_LATENCY);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, expected end of run");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.ovf_clr   = 1'b0;
    drive(0, 0, 0, 0, 1'b0, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_re", bus.out_re, 0);
    check("rst_out_im", bus.out_im, 0);
    check("rst_out_tag", bus.out_tag, 0);
    check("rst_ovf", bus.ovf, 0);
    check("rst_in_ready", bus.in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(1000, 0, 16384, 0, 1'b0, 1'b0, 'h15, 500, 0, 1'b1);
    send(0, 1000, 0, 16384, 1'b0, 1'b0, 'h21, -500, 0, 1'b1);
    send(0, 1000, 0, 16384, 1'b1, 1'b0, 'h22, 500, 0, 1'b1);
    send(3, 0, 16384, 0, 1'b0, 1'b1, 'h31, 2, 0, 1'b1);
    send(3, 0, 16384, 0, 1'b0, 1'b0, 'h32, 1, 0, 1'b1);
    send(-3, 0, 16384, 0, 1'b0, 1'b1, 'h33, -1, 0, 1'b1);
    send(-3, 0, 16384, 0, 1'b0, 1'b0, 'h34, -2, 0, 1'b1);
    wait_drain();
    check("ovf_clean", bus.ovf, 0);

    send(-2097152, -2097152, -32768, -32768, 1'b0, 1'b0, 'h3ff, 0, 2097151, 1'b1);
    wait_drain();
    check("ovf_set", bus.ovf, 1);
    repeat (5) @(posedge clk);
    #1;
    check("ovf_sticky", bus.ovf, 1);
    bus.ovf_clr = 1'b1;
    @(posedge clk); #1;
    bus.ovf_clr = 1'b0;
    check("ovf_cleared", bus.ovf, 0);

    bus.out_ready = 1'b0;
    k = 0;
    have_sample = 1'b0;
    stream(100, 10, 1'b0);
    check("stall_accepts", k, 4);
    check("stall_in_ready", bus.in_ready, 0);
    check("stall_out_valid", bus.out_valid, 1);
    stream(100, 3000, 1'b1);
    check("stream_count", k, 100);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    wait_drain();

    send(1000, 0, 16384, 0, 1'b0, 1'b0, 1, 500, 0, 1'b0);
    send(2000, 0, 16384, 0, 1'b0, 1'b0, 2, 1000, 0, 1'b0);
    send(4000, 0, 16384, 0, 1'b0, 1'b0, 3, 2000, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_out_re", bus.out_re, 0);
    check("mid_rst_out_im", bus.out_im, 0);
    check("mid_rst_out_tag", bus.out_tag, 0);
    check("mid_rst_ovf", bus.ovf, 0);
    check("mid_rst_in_ready", bus.in_ready, 1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("post_rst_idle", bus.out_valid, 0);
    send(-1000, 600, 16384, 0, 1'b0, 1'b0, 'h2a, -500, 300, 1'b1);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
